mem_arb: RTL and testbench

Shared-memory arbiter and access sequencer for the SISC datapath. It serialises three requesters onto the single-port memory: instruction fetch from the control FSM, data load/store for LOD/STR/SWP, and the debug/loader port. For each request it registers address and data, drives the memory strobe, waits a fixed read latency, and returns read data with a one-cycle completion pulse. The control FSM holds its fetch and mem states until the matching `done` pulse.

---
 rtl/mem_arb_if.sv | 35 +++
 rtl/mem_arb.sv | 204 ++++++++++++++++++++
 tb/tb_mem_arb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Requester-side and memory-side signal bundle for mem_arb.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_arb_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic [2:0]    req;
    logic [2:0]    we;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [DW-1:0] wdata2;
    logic          hold;
    logic [2:0]    gnt;
    logic [2:0]    done;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, hold, mem_rdata,
        output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, hold, mem_rdata,
        input  gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: serialises fetch, data and debug requesters onto one single-port memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority data > fetch > debug.
module mem_arb #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [1:0]    win_q, win_d;
    logic          we_q, we_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [2:0]    done_q, done_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]    sel_s;
    logic [AW-1:0] addr_sel_s;
    logic [DW-1:0] wdata_sel_s;
`ifdef MEM_ARB_RR_EN
    logic [1:0]    last_q, last_d;
`endif

`ifdef MEM_ARB_RR_EN
    function automatic logic [1:0] pick_rr(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] o0;
        logic [1:0] o1;
        logic [1:0] o2;
        case (last)
            2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
        if (r[o0]) begin
            return o0;
        end else if (r[o1]) begin
            return o1;
        end else begin
            return o2;
        end
    endfunction
`else
    function automatic logic [1:0] pick_fixed(input logic [2:0] r);
        if (r[1]) begin
            return 2'd1;
        end else if (r[0]) begin
            return 2'd0;
        end else begin
            return 2'd2;
        end
    endfunction
`endif

    // Winner selection and routing of its address and write data.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        sel_s = pick_rr(bus.req, last_q);
`else
        sel_s = pick_fixed(bus.req);
`endif
        case (sel_s)
            2'd0: begin
                addr_sel_s  = bus.addr0;
                wdata_sel_s = bus.wdata0;
            end
            2'd1: begin
                addr_sel_s  = bus.addr1;
                wdata_sel_s = bus.wdata1;
            end
            default: begin
                addr_sel_s  = bus.addr2;
                wdata_sel_s = bus.wdata2;
            end
        endcase
    end

    // Sequencer next state; outputs are computed for the state being entered so they stay registered.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        done_d      = 3'b000;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!bus.hold && (bus.req != 3'b000)) begin
                    state_d     = ST_ISSUE;
                    win_d       = sel_s;
                    we_d        = bus.we[sel_s];
                    gnt_d       = 3'b001 << sel_s;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.we[sel_s];
                    mem_addr_d  = addr_sel_s;
                    mem_wdata_d = wdata_sel_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // With MEM_LAT=1 the single WAIT cycle is the capture cycle, keeping done at T+2+MEM_LAT.
                cnt_d   = LAT_LOAD;
                state_d = ST_WAIT;
`ifdef MEM_ARB_RR_EN
                last_d  = win_q;
`endif
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    done_d  = gnt_q;
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            win_q       <= 2'd0;
            we_q        <= 1'b0;
            cnt_q       <= 4'd0;
            gnt_q       <= 3'b000;
            done_q      <= 3'b000;
            rdata_q     <= {DW{1'b0}};
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
`ifdef MEM_ARB_RR_EN
            last_q      <= 2'd2;
`endif
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: MEM_LAT=2 instance with a memory model, plus a MEM_LAT=1 instance.
module tb_mem_arb;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   en_cnt = 0;

    always #5 clk = ~clk;

    mem_arb_if #(.AW(16), .DW(32)) b0 ();
    mem_arb_if #(.AW(16), .DW(32)) b1 ();

    mem_arb #(.AW(16), .DW(32), .MEM_LAT(2)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    mem_arb #(.AW(16), .DW(32), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    logic [31:0]  mem [0:255];
    logic [255:0] wr_valid = '0;
    logic [31:0]  rd_p1;
    logic [31:0]  rd_p2;
    logic [31:0]  rd1;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        case (a)
            8'h10:   return 32'hDEADBEEF;
            8'h30:   return 32'h1111_0030;
            8'h31:   return 32'h2222_0031;
            8'h32:   return 32'h3333_0032;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Memory model: two-cycle read pipeline for dut0, one cycle for dut1.
    always @(posedge clk) begin
        if (b0.mem_en && b0.mem_we) begin
            mem[b0.mem_addr[7:0]]      <= b0.mem_wdata;
            wr_valid[b0.mem_addr[7:0]] <= 1'b1;
        end
        rd_p1 <= wr_valid[b0.mem_addr[7:0]] ? mem[b0.mem_addr[7:0]] : init_val(b0.mem_addr[7:0]);
        rd_p2 <= rd_p1;
        rd1   <= {16'hA5A5, b1.mem_addr};
        if (b0.mem_en) en_cnt <= en_cnt + 1;
    end

    assign b0.mem_rdata = rd_p2;
    assign b1.mem_rdata = rd1;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (b0.gnt !== 3'b000) begin bad++; $display("FAIL rst_gnt got=%b want=000", b0.gnt); end
        total++; if (b0.done !== 3'b000) begin bad++; $display("FAIL rst_done got=%b want=000", b0.done); end
        total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", b0.busy); end
        total++; if (b0.mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%b want=0", b0.mem_en); end
        total++; if (b0.rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", b0.rdata); end
        total++; if (b0.mem_addr !== 16'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", b0.mem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        int e0;
        e0 = en_cnt;
        b0.req = 3'b001; b0.we = 3'b000; b0.addr0 = 16'h0010;
        tick(); // T+1 ISSUE
        total++; if (b0.mem_en !== 1'b1) begin bad++; $display("FAIL rd_mem_en got=%b want=1", b0.mem_en); end
        total++; if (b0.gnt !== 3'b001) begin bad++; $display("FAIL rd_gnt_t1 got=%b want=001", b0.gnt); end
        total++; if (b0.mem_addr !== 16'h0010) begin bad++; $display("FAIL rd_mem_addr got=%h want=0010", b0.mem_addr); end
        b0.req = 3'b000;
        tick(); // T+2
        total++; if (b0.mem_en !== 1'b0) begin bad++; $display("FAIL rd_mem_en_t2 got=%b want=0", b0.mem_en); end
        tick(); // T+3
        total++; if (b0.done !== 3'b000) begin bad++; $display("FAIL rd_done_t3 got=%b want=000", b0.done); end
        tick(); // T+4
        total++; if (b0.done !== 3'b001) begin bad++; $display("FAIL rd_done_t4 got=%b want=001", b0.done); end
        total++; if (b0.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata got=%h want=deadbeef", b0.rdata); end
        total++; if (b0.gnt !== 3'b001) begin bad++; $display("FAIL rd_gnt_t4 got=%b want=001", b0.gnt); end
        tick(); // T+5
        total++; if (b0.gnt !== 3'b000) begin bad++; $display("FAIL rd_gnt_t5 got=%b want=000", b0.gnt); end
        total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL rd_busy_t5 got=%b want=0", b0.busy); end
        total++; if (en_cnt - e0 !== 1) begin bad++; $display("FAIL rd_en_pulses got=%0d want=1", en_cnt - e0); end
    endtask

    task automatic test_write();
        b0.req = 3'b010; b0.we = 3'b010; b0.addr1 = 16'h0020; b0.wdata1 = 32'h12345678;
        tick(); // T+1
        total++; if (b0.mem_en !== 1'b1 || b0.mem_we !== 1'b1) begin bad++; $display("FAIL wr_strobe got en=%b we=%b want 1 1", b0.mem_en, b0.mem_we); end
        total++; if (b0.mem_wdata !== 32'h12345678) begin bad++; $display("FAIL wr_wdata got=%h want=12345678", b0.mem_wdata); end
        b0.req = 3'b000; b0.we = 3'b000;
        tick(); tick(); tick(); // T+4
        total++; if (b0.done !== 3'b010) begin bad++; $display("FAIL wr_done got=%b want=010", b0.done); end
        total++; if (b0.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rdata_kept got=%h want=deadbeef", b0.rdata); end
        tick();
        b0.req = 3'b001; b0.addr0 = 16'h0020;
        tick();
        b0.req = 3'b000;
        tick(); tick(); tick();
        total++; if (b0.done !== 3'b001) begin bad++; $display("FAIL wr_rb_done got=%b want=001", b0.done); end
        total++; if (b0.rdata !== 32'h12345678) begin bad++; $display("FAIL wr_readback got=%h want=12345678", b0.rdata); end
        tick();
    endtask

    task automatic test_hold();
        b0.req = 3'b001; b0.addr0 = 16'h0010;
        tick(); // ISSUE
        b0.req = 3'b000;
        tick(); // WAIT
        b0.hold = 1'b1; b0.req = 3'b001;
        tick(); tick(); // DONE
        total++; if (b0.done !== 3'b001) begin bad++; $display("FAIL hold_done got=%b want=001", b0.done); end
        tick(); tick(); // IDLE, held
        total++; if (b0.gnt !== 3'b000 || b0.busy !== 1'b0) begin bad++; $display("FAIL hold_no_gnt got gnt=%b busy=%b want 000 0", b0.gnt, b0.busy); end
        b0.hold = 1'b0;
        tick();
        total++; if (b0.gnt !== 3'b001 || b0.mem_en !== 1'b1) begin bad++; $display("FAIL hold_release got gnt=%b en=%b want 001 1", b0.gnt, b0.mem_en); end
        b0.req = 3'b000;
        tick(); tick(); tick();
        total++; if (b0.done !== 3'b001) begin bad++; $display("FAIL hold_done2 got=%b want=001", b0.done); end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        b0.req = 3'b010; b0.we = 3'b000; b0.addr1 = 16'h0030;
        tick(); // ISSUE
        b0.req = 3'b000;
        tick(); // WAIT
        rst = 1'b1;
        tick();
        total++; if (b0.gnt !== 3'b000 || b0.done !== 3'b000 || b0.busy !== 1'b0) begin bad++; $display("FAIL rmid_ctl got gnt=%b done=%b busy=%b want all 0", b0.gnt, b0.done, b0.busy); end
        total++; if (b0.mem_en !== 1'b0 || b0.mem_we !== 1'b0) begin bad++; $display("FAIL rmid_strobe got en=%b we=%b want 0 0", b0.mem_en, b0.mem_we); end
        total++; if (b0.mem_addr !== 16'h0 || b0.mem_wdata !== 32'h0 || b0.rdata !== 32'h0) begin bad++; $display("FAIL rmid_data got addr=%h wdata=%h rdata=%h want 0", b0.mem_addr, b0.mem_wdata, b0.rdata); end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b0.done !== 3'b000) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", seen); end
    endtask

    task automatic test_simultaneous();
        logic [1:0]  order [3];
        logic [31:0] exp_data [3];
        logic [2:0]  eg;
        logic [2:0]  r;
        logic [1:0]  w;
`ifdef MEM_ARB_RR_EN
        order = '{2'd0, 2'd1, 2'd2};
`else
        order = '{2'd1, 2'd0, 2'd2};
`endif
        exp_data = '{32'h1111_0030, 32'h2222_0031, 32'h3333_0032};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b0.we = 3'b000; b0.addr0 = 16'h0030; b0.addr1 = 16'h0031; b0.addr2 = 16'h0032;
        b0.req = 3'b111;
        for (int k = 0; k < 3; k++) begin
            w  = order[k];
            eg = 3'b001 << w;
            tick(); // ISSUE
            total++; if (b0.gnt !== eg) begin bad++; $display("FAIL sim_gnt_%0d got=%b want=%b", k, b0.gnt, eg); end
            tick(); tick(); tick(); // DONE
            total++; if (b0.done !== eg) begin bad++; $display("FAIL sim_done_%0d got=%b want=%b", k, b0.done, eg); end
            total++; if (b0.rdata !== exp_data[w]) begin bad++; $display("FAIL sim_rdata_%0d got=%h want=%h", k, b0.rdata, exp_data[w]); end
            r = b0.req;
            r[w] = 1'b0;
            b0.req = r;
            tick(); // IDLE
        end
        total++; if (b0.busy !== 1'b0 || b0.gnt !== 3'b000) begin bad++; $display("FAIL sim_idle got busy=%b gnt=%b want 0 000", b0.busy, b0.gnt); end
    endtask

    task automatic test_lat1();
        b1.req = 3'b001; b1.we = 3'b000; b1.addr0 = 16'h0005;
        tick(); // ISSUE
        total++; if (b1.gnt !== 3'b001 || b1.mem_en !== 1'b1) begin bad++; $display("FAIL lat1_issue got gnt=%b en=%b want 001 1", b1.gnt, b1.mem_en); end
        b1.req = 3'b000;
        tick(); // T+2
        total++; if (b1.done !== 3'b000) begin bad++; $display("FAIL lat1_done_t2 got=%b want=000", b1.done); end
        tick(); // T+3
        total++; if (b1.done !== 3'b001) begin bad++; $display("FAIL lat1_done_t3 got=%b want=001", b1.done); end
        total++; if (b1.rdata !== 32'hA5A50005) begin bad++; $display("FAIL lat1_rdata got=%h want=a5a50005", b1.rdata); end
        tick();
        total++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL lat1_idle got=%b want=0", b1.busy); end
    endtask

    initial begin
        rst = 1'b1;
        b0.req = 3'b000; b0.we = 3'b000; b0.hold = 1'b0;
        b0.addr0 = 16'h0; b0.addr1 = 16'h0; b0.addr2 = 16'h0;
        b0.wdata0 = 32'h0; b0.wdata1 = 32'h0; b0.wdata2 = 32'h0;
        b1.req = 3'b000; b1.we = 3'b000; b1.hold = 1'b0;
        b1.addr0 = 16'h0; b1.addr1 = 16'h0; b1.addr2 = 16'h0;
        b1.wdata0 = 32'h0; b1.wdata1 = 32'h0; b1.wdata2 = 32'h0;
        test_reset();
        test_single_read();
        test_write();
        test_hold();
        test_reset_mid();
        test_simultaneous();
        test_lat1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
